// File: rtl/ps2_interface.sv
// ps2_interface: receive-only PS/2 host port.
// Synchronizes and deglitches the keyboard clock/data lines, deserializes
// 11-bit device-to-host frames, and emits a one-cycle read_data strobe with
// the scan-code byte and an error flag.
//
// State table
//   state   | meaning
//   ST_IDLE | bus idle, waiting for the start-bit falling edge
//   ST_RECV | frame in progress, shifting bits, timeout counter running
//   ST_DONE | one-cycle frame completion, read_data/err presented
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   ps2_clk   : PS/2 clock line (open-collector, never driven here)
//   ps2_data  : PS/2 data line (open-collector, never driven here)
//   rx_data   : last valid received byte
//   read_data : one-cycle strobe at frame completion
//   busy      : high while a frame is being received
//   err       : framing/parity error, only meaningful with read_data
module ps2_interface #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_US  = 200
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic [7:0] rx_data,
   output logic       read_data,
   output logic       busy,
   output logic       err
);

   localparam int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * TIMEOUT_US;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FLT_W          = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Host is receive-only: both open-collector lines are released.
   assign ps2_clk  = 1'bz;
   assign ps2_data = 1'bz;

   logic             clk_s1, clk_s2;
   logic             data_s1, data_s2;
   logic             clk_f, clk_f_q;
   logic [FLT_W-1:0] flt_cnt;
   logic             fall;

   state_t           state, state_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [10:0]      frame, frame_n;
   logic [TO_W-1:0]  to_cnt, to_cnt_n;
   logic             load_rx;

   // Frame layout after 11 shifts: [0]=start, [8:1]=D7..D0, [9]=parity, [10]=stop.
   function automatic logic frame_good(input logic [10:0] f);
      return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
         clk_f   <= 1'b1;
         clk_f_q <= 1'b1;
         flt_cnt <= '0;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
         clk_f_q <= clk_f;
         // Filtered clock follows only after FILTER_LEN consecutive
         // differing samples; any agreeing sample restarts the run.
         if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            clk_f   <= clk_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
         end
      end
   end

   assign fall = clk_f_q & ~clk_f;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         frame   <= '0;
         to_cnt  <= '0;
         rx_data <= 8'h00;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         frame   <= frame_n;
         to_cnt  <= to_cnt_n;
         if (load_rx) begin
            rx_data <= frame_n[8:1];
         end
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      frame_n   = frame;
      to_cnt_n  = to_cnt;
      load_rx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fall) begin
               frame_n   = {data_s2, frame[10:1]};
               bit_cnt_n = 4'd1;
               to_cnt_n  = TO_W'(TIMEOUT_CYCLES - 1);
               state_n   = ST_RECV;
            end
         end
         ST_RECV: begin
            if (fall) begin
               frame_n   = {data_s2, frame[10:1]};
               bit_cnt_n = bit_cnt + 4'd1;
               to_cnt_n  = TO_W'(TIMEOUT_CYCLES - 1);
               if (bit_cnt == 4'd10) begin
                  // rx_data must already hold the new byte in the strobe cycle.
                  state_n = ST_DONE;
                  load_rx = frame_good(frame_n);
               end
            end else if (to_cnt == '0) begin
               state_n   = ST_IDLE;
               bit_cnt_n = '0;
            end else begin
               to_cnt_n = to_cnt - TO_W'(1);
            end
         end
         ST_DONE: begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
         end
         default: begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
         end
      endcase
   end

   assign read_data = (state == ST_DONE);
   assign busy      = (state == ST_RECV);
   assign err       = (state == ST_DONE) && !frame_good(frame);

endmodule

// File: tb/tb_ps2_interface.sv
// Self-checking bench for ps2_interface: drives PS/2 frames on the bus lines
// and compares strobes against a frame-level reference model.
module tb_ps2_interface;

   localparam int H = 25;   // PS/2 half period in clk cycles

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clk_drv = 1'b1;
   logic       dat_drv = 1'b1;
   wire        ps2_clk_w;
   wire        ps2_data_w;
   logic [7:0] rx_data;
   logic       read_data, busy, err;

   assign ps2_clk_w  = clk_drv;
   assign ps2_data_w = dat_drv;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] model_rx = 8'h00;

   logic [7:0] q_data[$];
   logic       q_err[$];
   logic       q_busy[$];
   int         width_viol = 0;
   int         err_viol = 0;
   int         rx_viol = 0;
   logic       prev_rd = 1'b0;
   logic [7:0] prev_rx = 8'h00;
   logic       busy_seen = 1'b0;

   always #5 clk = ~clk;

   ps2_interface dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk_w),
      .ps2_data  (ps2_data_w),
      .rx_data   (rx_data),
      .read_data (read_data),
      .busy      (busy),
      .err       (err)
   );

   always @(negedge clk) begin
      if (read_data === 1'b1) begin
         q_data.push_back(rx_data);
         q_err.push_back(err);
         q_busy.push_back(busy);
      end
      if (read_data === 1'b1 && prev_rd === 1'b1) width_viol++;
      if (err === 1'b1 && read_data !== 1'b1) err_viol++;
      if (reset && read_data !== 1'b1 && rx_data !== prev_rx) rx_viol++;
      if (busy === 1'b1) busy_seen = 1'b1;
      prev_rd = read_data;
      prev_rx = rx_data;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic [7:0] d, input logic bad_start,
                             input logic bad_par, input logic bad_stop,
                             input int nbits, input int glitch_bit);
      logic [10:0] bits;
      bits = {~bad_stop, (~^d) ^ bad_par, d, bad_start};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         dat_drv = bits[i];
         repeat (H) @(negedge clk);
         clk_drv = 1'b0;
         repeat (H) @(negedge clk);
         clk_drv = 1'b1;
         if (i == glitch_bit) begin
            repeat (12) @(negedge clk);
            clk_drv = 1'b0;
            repeat (3) @(negedge clk);
            clk_drv = 1'b1;
         end
      end
      repeat (H) @(negedge clk);
      dat_drv = 1'b1;
   endtask

   // Sends one full frame, advances the reference model, and returns what
   // the monitor captured alongside what the model expects.
   task automatic run_frame(input logic [7:0] d, input logic bs, input logic bp,
                            input logic bst, input int glitch_bit,
                            output int n_strobe, output logic [7:0] got_d,
                            output logic got_err, output logic got_busy,
                            output logic saw_busy,
                            output logic [7:0] exp_d, output logic exp_err);
      q_data.delete(); q_err.delete(); q_busy.delete();
      busy_seen = 1'b0;
      send_frame(d, bs, bp, bst, 11, glitch_bit);
      repeat (10) @(negedge clk);
      exp_err = bs | bp | bst;
      if (!exp_err) model_rx = d;
      exp_d    = model_rx;
      n_strobe = q_data.size();
      saw_busy = busy_seen;
      got_d = 8'hxx; got_err = 1'bx; got_busy = 1'bx;
      if (n_strobe > 0) begin
         got_d    = q_data.pop_front();
         got_err  = q_err.pop_front();
         got_busy = q_busy.pop_front();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      n_cmp++; if (read_data !== 1'b0) begin n_fail++; $display("FAIL reset_read_data: got %b want 0", read_data); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b1;
      repeat (50) @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || read_data !== 1'b0) begin n_fail++; $display("FAIL idle_bus: got busy=%b rd=%b want 0 0", busy, read_data); end
   endtask

   task automatic test_valid();
      int n; logic [7:0] gd, ed; logic ge, gb, sb, ee;
      run_frame(8'h1C, 0, 0, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL valid_strobes: got %0d want 1", n); end
      n_cmp++; if (gd !== 8'h1C) begin n_fail++; $display("FAIL valid_data: got %h want 1c", gd); end
      n_cmp++; if (ge !== 1'b0) begin n_fail++; $display("FAIL valid_err: got %b want 0", ge); end
      n_cmp++; if (gb !== 1'b0) begin n_fail++; $display("FAIL valid_busy_at_strobe: got %b want 0", gb); end
      n_cmp++; if (sb !== 1'b1) begin n_fail++; $display("FAIL valid_busy_during: got %b want 1", sb); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL valid_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_break_make();
      int n; logic [7:0] gd, ed; logic ge, gb, sb, ee;
      run_frame(8'hF0, 0, 0, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || gd !== 8'hF0 || ge !== 1'b0) begin n_fail++; $display("FAIL break_f0: got n=%0d d=%h e=%b want 1 f0 0", n, gd, ge); end
      run_frame(8'h1C, 0, 0, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || gd !== 8'h1C || ge !== 1'b0) begin n_fail++; $display("FAIL make_1c: got n=%0d d=%h e=%b want 1 1c 0", n, gd, ge); end
   endtask

   task automatic test_bad_frames();
      int n; logic [7:0] gd, ed; logic ge, gb, sb, ee;
      run_frame(8'h1C, 0, 1, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || ge !== 1'b1) begin n_fail++; $display("FAIL bad_parity_err: got n=%0d e=%b want 1 1", n, ge); end
      n_cmp++; if (gd !== ed) begin n_fail++; $display("FAIL bad_parity_hold: got %h want %h", gd, ed); end
      run_frame(8'h5A, 0, 0, 1, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || ge !== 1'b1 || gd !== ed) begin n_fail++; $display("FAIL bad_stop: got n=%0d d=%h e=%b want 1 %h 1", n, gd, ge, ed); end
      run_frame(8'hA5, 1, 0, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || ge !== 1'b1 || gd !== ed) begin n_fail++; $display("FAIL bad_start: got n=%0d d=%h e=%b want 1 %h 1", n, gd, ge, ed); end
   endtask

   task automatic test_random();
      int n; logic [7:0] gd, ed, d; logic ge, gb, sb, ee, bs, bp, bst;
      int kind;
      for (int k = 0; k < 12; k++) begin
         d = 8'($urandom_range(0, 255));
         kind = int'($urandom_range(0, 5));
         bs = (kind == 3); bp = (kind == 4); bst = (kind == 5);
         run_frame(d, bs, bp, bst, -1, n, gd, ge, gb, sb, ed, ee);
         n_cmp++;
         if (n !== 1 || gd !== ed || ge !== ee || gb !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d: got n=%0d d=%h e=%b b=%b want 1 %h %b 0", k, n, gd, ge, gb, ed, ee);
         end
      end
   endtask

   task automatic test_timeout();
      int n; logic [7:0] gd, ed; logic ge, gb, sb, ee;
      q_data.delete(); q_err.delete(); q_busy.delete();
      send_frame(8'h55, 0, 0, 0, 5, -1);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_partial: got %b want 1", busy); end
      repeat (15000) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_early: got %b want 1", busy); end
      repeat (10000) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_late: got %b want 0", busy); end
      n_cmp++; if (q_data.size() !== 0) begin n_fail++; $display("FAIL timeout_no_strobe: got %0d want 0", q_data.size()); end
      run_frame(8'h29, 0, 0, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || gd !== 8'h29 || ge !== 1'b0) begin n_fail++; $display("FAIL timeout_recover: got n=%0d d=%h e=%b want 1 29 0", n, gd, ge); end
   endtask

   task automatic test_glitch();
      int n; logic [7:0] gd, ed; logic ge, gb, sb, ee;
      q_data.delete(); q_err.delete(); q_busy.delete();
      busy_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         clk_drv = 1'b0;
         repeat (3) @(negedge clk);
         clk_drv = 1'b1;
         repeat (20) @(negedge clk);
      end
      n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_busy: got %b want 0", busy_seen); end
      n_cmp++; if (q_data.size() !== 0) begin n_fail++; $display("FAIL glitch_idle_strobe: got %0d want 0", q_data.size()); end
      run_frame(8'h1C, 0, 0, 0, 4, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || gd !== 8'h1C || ge !== 1'b0) begin n_fail++; $display("FAIL glitch_midframe: got n=%0d d=%h e=%b want 1 1c 0", n, gd, ge); end
   endtask

   task automatic test_reset_mid();
      int n; logic [7:0] gd, ed; logic ge, gb, sb, ee;
      q_data.delete(); q_err.delete(); q_busy.delete();
      send_frame(8'h77, 0, 0, 0, 5, -1);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      model_rx = 8'h00;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_cmp++; if (rx_data !== model_rx) begin n_fail++; $display("FAIL rstmid_rx: got %h want %h", rx_data, model_rx); end
      reset = 1'b1;
      repeat (50) @(negedge clk);
      n_cmp++; if (q_data.size() !== 0) begin n_fail++; $display("FAIL rstmid_strobe: got %0d want 0", q_data.size()); end
      run_frame(8'h32, 0, 0, 0, -1, n, gd, ge, gb, sb, ed, ee);
      n_cmp++; if (n !== 1 || gd !== 8'h32 || ge !== 1'b0) begin n_fail++; $display("FAIL rstmid_next: got n=%0d d=%h e=%b want 1 32 0", n, gd, ge); end
   endtask

   task automatic test_invariants();
      n_cmp++; if (width_viol !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d wide strobes want 0", width_viol); end
      n_cmp++; if (err_viol !== 0) begin n_fail++; $display("FAIL err_without_strobe: got %0d want 0", err_viol); end
      n_cmp++; if (rx_viol !== 0) begin n_fail++; $display("FAIL rx_data_stability: got %0d changes want 0", rx_viol); end
   endtask

   initial begin
      test_reset();
      test_valid();
      test_break_make();
      test_bad_frames();
      test_random();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
